// File: rtl/key_debounce.sv
// key_debounce
//   Samples KEY_W active-low push-buttons, debounces each with its own filter
//   FSM and emits one-cycle press / release / long-press pulses plus the index
//   of the lowest key that produced a press pulse.
//
// Parameters
//   KEY_W      number of keys (1..8)
//   CNT_MAX    filter period minus 1, in clk cycles
//   LONG_TICKS filter periods held down before key_long fires (0 = disabled)
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   key_n        raw buttons, asynchronous, 0 = pressed
//   key_state    debounced level, 1 = pressed
//   key_press    one-cycle pulse per key on debounced press
//   key_release  one-cycle pulse per key on debounced release
//   key_long     one-cycle pulse per key, at most once per press, on long hold
//   key_valid    one-cycle pulse when any key_press bit is set
//   key_code     index of lowest key pulsing key_press; holds otherwise
module key_debounce #(
  parameter int unsigned KEY_W      = 4,
  parameter logic [19:0] CNT_MAX    = 20'd999_999,
  parameter logic [7:0]  LONG_TICKS = 8'd50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_n,
  output logic [KEY_W-1:0] key_state,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic [KEY_W-1:0] key_long,
  output logic             key_valid,
  output logic [2:0]       key_code
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PFILT = 2'd1,
    DOWN  = 2'd2,
    RFILT = 2'd3
  } state_t;

  logic [KEY_W-1:0] sync1;
  logic [KEY_W-1:0] ks;
  state_t           st   [KEY_W];
  logic [19:0]      cnt  [KEY_W];
  logic [7:0]       lcnt [KEY_W];

  logic [KEY_W-1:0] press_nxt;
  logic [2:0]       code_nxt;
  logic             code_hit;

  // Two-flop synchronizer; released (1) after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      ks    <= '1;
    end else begin
      sync1 <= key_n;
      ks    <= sync1;
    end
  end

  // Press condition is needed by both the per-key FSMs and the shared
  // key_valid/key_code encoder, so it is decoded once here.
  always_comb begin
    press_nxt = '0;
    for (int unsigned i = 0; i < KEY_W; i++) begin
      press_nxt[i] = (st[i] == PFILT) && !ks[i] && (cnt[i] == CNT_MAX);
    end
  end

  always_comb begin
    code_nxt = key_code;
    code_hit = 1'b0;
    for (int unsigned i = 0; i < KEY_W; i++) begin
      if (press_nxt[i] && !code_hit) begin
        code_nxt = 3'(i);
        code_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < KEY_W; i++) begin
        st[i]   <= IDLE;
        cnt[i]  <= '0;
        lcnt[i] <= '0;
      end
      key_state   <= '0;
      key_press   <= '0;
      key_release <= '0;
      key_long    <= '0;
      key_valid   <= 1'b0;
      key_code    <= '0;
    end else begin
      key_press   <= press_nxt;
      key_valid   <= |press_nxt;
      key_code    <= code_nxt;
      key_release <= '0;
      key_long    <= '0;
      for (int unsigned i = 0; i < KEY_W; i++) begin
        case (st[i])
          IDLE: begin
            if (!ks[i]) begin
              st[i]  <= PFILT;
              cnt[i] <= '0;
            end
          end
          PFILT: begin
            if (ks[i]) begin
              st[i] <= IDLE;
            end else if (press_nxt[i]) begin
              st[i]        <= DOWN;
              cnt[i]       <= '0;
              lcnt[i]      <= '0;
              key_state[i] <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + 20'd1;
            end
          end
          DOWN: begin
            if (ks[i]) begin
              st[i]  <= RFILT;
              cnt[i] <= '0;
            end else if (cnt[i] == CNT_MAX) begin
              cnt[i] <= '0;
              // lcnt saturates at LONG_TICKS, so the pulse fires only on the
              // wrap that first reaches it; LONG_TICKS=0 never increments.
              if (lcnt[i] != LONG_TICKS) begin
                lcnt[i] <= lcnt[i] + 8'd1;
                if ((lcnt[i] + 8'd1) == LONG_TICKS) begin
                  key_long[i] <= 1'b1;
                end
              end
            end else begin
              cnt[i] <= cnt[i] + 20'd1;
            end
          end
          RFILT: begin
            if (!ks[i]) begin
              // Release glitch: resume holding, long-press progress kept.
              st[i]  <= DOWN;
              cnt[i] <= '0;
            end else if (cnt[i] == CNT_MAX) begin
              st[i]          <= IDLE;
              key_release[i] <= 1'b1;
              key_state[i]   <= 1'b0;
            end else begin
              cnt[i] <= cnt[i] + 20'd1;
            end
          end
          default: st[i] <= IDLE;
        endcase
      end
    end
  end

endmodule
